// File: rtl/mult_div.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// Sits beside the ALU in the execute stage. Multiplies finish in one cycle
// after acceptance. Divides use restoring shift-subtract on operand
// magnitudes, one quotient bit per cycle, 32 cycles. MTHI/MTLO write in the
// accepting cycle and never raise busy.
//
// Ports:
//   clk     - clock, rising edge
//   resetn  - asynchronous active-low reset
//   start   - request valid, honoured only in idle with flush low
//   op      - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b    - rs / rt operands
//   flush   - aborts an in-flight operation; blocks a same-cycle start
//   busy    - operation in flight (registered state decode)
//   done    - one-cycle pulse the cycle after HI/LO are written
//   hi, lo  - HI/LO architectural registers
module mult_div (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;   // signed variant of the latched op
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;   // partial remainder
  logic [31:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Multiply datapath: sign- or zero-extend to 64 bits, keep the low 64.
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  // Divide datapath: one restoring step per cycle.
  logic [31:0] a_mag, dmag;
  logic [32:0] shifted, diff;
  logic        ge;
  logic [31:0] rem_nx, quo_nx, quo_fix, rem_fix;

  assign a_mag   = (~op[0] & a[31]) ? (32'd0 - a) : a;
  assign dmag    = (sgn_q & b_q[31]) ? (32'd0 - b_q) : b_q;
  assign shifted = {rem_q, quo_q[31]};
  assign ge      = shifted >= {1'b0, dmag};
  assign diff    = shifted - {1'b0, dmag};
  assign rem_nx  = ge ? diff[31:0] : shifted[31:0];
  assign quo_nx  = {quo_q[30:0], ge};
  // Quotient negated on differing signs; remainder follows the dividend.
  // 0x80000000 / -1 wraps back to 0x80000000 through the negation.
  assign quo_fix = (sgn_q & (a_q[31] ^ b_q[31])) ? (32'd0 - quo_nx) : quo_nx;
  assign rem_fix = (sgn_q & a_q[31]) ? (32'd0 - rem_nx) : rem_nx;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          unique case (op)
            OpMult, OpMultu: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = ~op[0];
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = ~op[0];
              cnt_d   = 5'd0;
              rem_d   = 32'd0;
              quo_d   = a_mag;
              state_d = StDiv;
            end
            OpMthi: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OpMtlo: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: ;  // reserved encodings are ignored
          endcase
        end
      end
      StMul: begin
        state_d = StIdle;
        if (!flush) begin
          hi_d   = prod[63:32];
          lo_d   = prod[31:0];
          done_d = 1'b1;
        end
      end
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StIdle;
            done_d  = 1'b1;
            // Divide-by-zero runs full length but leaves HI/LO untouched.
            if (b_q != 32'd0) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: expected HI/LO pairs go into a scoreboard
// queue when a request is issued and are popped when done pulses.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] sb[$];

  mult_div dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request in the current cycle (cycle 0), then follow it to its
  // done cycle at the given latency and compare HI/LO with the scoreboard.
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int lat, input logic [63:0] expv, input string tag);
    sb.push_back(expv);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
    for (int c = 1; c < lat; c++) begin
      check({tag, " busy"}, {63'd0, busy}, 64'd1);
      check({tag, " done early"}, {63'd0, done}, 64'd0);
      step();
    end
    check({tag, " busy end"}, {63'd0, busy}, 64'd0);
    check({tag, " done"}, {63'd0, done}, 64'd1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      check({tag, " hi:lo"}, {hi, lo}, sb.pop_front());
    end
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 3'b000;
    a      = 32'd0;
    b      = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi:lo", {hi, lo}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    resetn = 1'b1;
    step();

    // MTHI then MTLO back-to-back in the done cycle.
    run(3'b100, 32'h1234_5678, 32'd0, 1, {32'h1234_5678, 32'h0000_0000}, "mthi");
    run(3'b101, 32'h9ABC_DEF0, 32'd0, 1, {32'h1234_5678, 32'h9ABC_DEF0}, "mtlo");

    run(3'b000, 32'hFFFF_FFFF, 32'h2, 2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, "mult");
    run(3'b001, 32'hFFFF_FFFF, 32'h2, 2, {32'h0000_0001, 32'hFFFF_FFFE}, "multu");

    // Reserved op: no write, no done.
    start = 1'b1;
    op    = 3'b110;
    a     = 32'h5555_5555;
    step();
    start = 1'b0;
    check("reserved done", {63'd0, done}, 64'd0);
    check("reserved busy", {63'd0, busy}, 64'd0);
    check("reserved hi:lo", {hi, lo}, {32'h0000_0001, 32'hFFFF_FFFE});

    run(3'b010, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div -7/2");
    run(3'b011, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "divu 100/7");
    run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000}, "div wrap");

    run(3'b100, 32'hA, 32'd0, 1, {32'hA, 32'h8000_0000}, "mthi A");
    run(3'b101, 32'hB, 32'd0, 1, {32'hA, 32'hB}, "mtlo B");
    run(3'b011, 32'd5, 32'd0, 33, {32'hA, 32'hB}, "divu by zero");

    // Flush at cycle 10 of a DIVU; start held high in cycles 1..9 must be ignored.
    start = 1'b1;
    op    = 3'b011;
    a     = 32'd1000;
    b     = 32'd3;
    step();
    op    = 3'b100;
    a     = 32'hDEAD_0000;
    for (int c = 1; c < 10; c++) begin
      check("flush busy pre", {63'd0, busy}, 64'd1);
      check("flush done pre", {63'd0, done}, 64'd0);
      step();
    end
    start = 1'b0;
    flush = 1'b1;
    check("flush busy c10", {63'd0, busy}, 64'd1);
    step();
    flush = 1'b0;
    check("flush busy c11", {63'd0, busy}, 64'd0);
    check("flush done c11", {63'd0, done}, 64'd0);
    check("flush hi:lo", {hi, lo}, {32'hA, 32'hB});

    // Flush in idle blocks a same-cycle start.
    start = 1'b1;
    flush = 1'b1;
    op    = 3'b100;
    a     = 32'h55;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("idle flush done", {63'd0, done}, 64'd0);
    check("idle flush hi:lo", {hi, lo}, {32'hA, 32'hB});
    step();
    check("idle flush busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset at cycle 5 of a DIV.
    start = 1'b1;
    op    = 3'b010;
    a     = 32'd20;
    b     = 32'd3;
    step();
    start = 1'b0;
    repeat (4) step();
    check("pre-reset busy", {63'd0, busy}, 64'd1);
    resetn = 1'b0;
    #1;
    check("async reset hi:lo", {hi, lo}, 64'd0);
    check("async reset busy", {63'd0, busy}, 64'd0);
    check("async reset done", {63'd0, done}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    run(3'b001, 32'd3, 32'd5, 2, {32'd0, 32'd15}, "multu 3x5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. It sits beside the ALU and consumes the same execute-stage operands (rs → `a`, rt → `b`). Its `hi`/`lo` outputs feed the ALU's pass-through path, so MFHI/MFLO reach writeback through the ALU. It stalls the pipeline via `busy` during multi-cycle operations.

## Interface
- No parameters. Data width is fixed at 32 bits; the product and HI:LO pair are 64 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `start` in 1: request valid; sampled at the rising edge.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- `a` in 32: rs operand (multiplicand / dividend / MTHI-MTLO data).
- `b` in 32: rt operand (multiplier / divisor).
- `flush` in 1: pipeline flush; aborts the operation in flight.
- `busy` out 1: high while a MUL/DIV is in flight; the hazard unit stalls on it.
- `done` out 1: one-cycle pulse the cycle after HI/LO are written.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, MUL, DIV. `busy` = (state != IDLE).
- Accept rule: a request is accepted in IDLE when `start`=1 and `flush`=0.
  - `start` in MUL/DIV is ignored; it is not queued.
  - Reserved `op` values are ignored: no write, no `done`.
- Acceptance of MULT/MULTU/DIV/DIVU:
  - latch `a`, `b`, `op`;
  - go to MUL (multiplies) or DIV (divides);
  - in DIV, load iteration counter = 0.
- MTHI/MTLO: `hi` (or `lo`) ← `a` at the accepting edge. State stays IDLE and `busy` never asserts.
- MUL (one cycle):
  - 64-bit product of the latched operands: signed for MULT, unsigned for MULTU;
  - {hi,lo} ← product; return to IDLE.
- DIV (32 cycles):
  - Restoring shift-subtract on operand magnitudes, one quotient bit per cycle; counter 0..31.
  - At counter = 31: lo ← quotient, hi ← remainder; return to IDLE.
  - DIV signed fix-up: quotient negated if sign(a)≠sign(b); remainder takes the sign of `a`.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0 (two's-complement wrap).
  - Divisor 0: full 32-cycle latency; hi/lo left unchanged; `done` still pulses.
- `done` pulses for one cycle after every completed write: MUL, DIV (including divide-by-zero), MTHI, MTLO.
- Flush:
  - `flush`=1 in MUL or DIV aborts: next state IDLE, hi/lo unchanged, no `done`.
  - `flush` in IDLE blocks any same-cycle `start`.
- Reset (async, `resetn`=0): hi=0, lo=0, `busy`=0, `done`=0, state IDLE, counter 0. Asserting reset mid-operation discards the operation immediately.

## Timing
- Cycle numbering: cycle 0 = cycle in which `start` is sampled high and accepted (edge E0 ends it).
- MTHI/MTLO:
  - hi/lo visible from cycle 1;
  - `done`=1 in cycle 1;
  - `busy`=0 throughout.
- MULT/MULTU:
  - `busy`=1 in cycle 1;
  - hi/lo written at E1 and visible in cycle 2;
  - `done`=1 and `busy`=0 in cycle 2.
  - Latency 2.
- DIV/DIVU:
  - `busy`=1 in cycles 1..32;
  - hi/lo written at E32 and visible in cycle 33;
  - `done`=1 and `busy`=0 in cycle 33.
  - Latency 33.
- Back-to-back: a new `start` may be accepted in the cycle `done` is high, because the state is already IDLE.
- `hi`/`lo` are register outputs with no combinational path from inputs. A same-cycle MFHI after MTHI must be handled by the hazard unit, not here.
- `busy` is a registered state decode, valid from the cycle after acceptance.

## Test plan
- Reset then MTHI a=0x12345678, followed by MTLO a=0x9ABCDEF0 → cycle 1 after each: hi=0x12345678, then lo=0x9ABCDEF0; `done` pulses twice; `busy` never 1.
- MULT a=0xFFFFFFFF (−1), b=0x00000002 → cycle 2: hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done`=1. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → `busy` high cycles 1..32; cycle 33: lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU with b=0 and prior hi/lo=0xA/0xB → after 33 cycles hi=0xA, lo=0xB, `done`=1.
- DIVU started, `flush`=1 at cycle 10 → `busy`=0 from cycle 11, no `done`, hi/lo unchanged; `start` held high during cycles 1..9 is ignored.
- `resetn` pulled low at cycle 5 of a DIV → hi=lo=0 and `busy`=`done`=0 immediately (asynchronous); after release, MULTU 3×5 → lo=15, hi=0 at cycle 2.
